// File: rtl/mipi_csi_pkg.sv
// mipi_csi_pkg: CSI-2 data-type constants and line sequencer state encoding
package mipi_csi_pkg;
  localparam logic [5:0] DT_FS    = 6'h00;
  localparam logic [5:0] DT_FE    = 6'h01;
  localparam logic [5:0] DT_LS    = 6'h02;
  localparam logic [5:0] DT_LE    = 6'h03;
  localparam logic [5:0] DT_RAW10 = 6'h2B;
  localparam logic [5:0] DT_RAW12 = 6'h2C;
  localparam logic [5:0] DT_RAW14 = 6'h2D;
  localparam logic [5:0] DT_LONG_MIN = 6'h10;
  localparam logic [2:0] DT_TYPE_MASK = 3'h7;
  typedef enum logic [2:0] {ST_IDLE, ST_FRAME, ST_LINE, ST_GUARD, ST_DROP} state_t;
  function automatic logic is_raw(input logic [5:0] dt);
    return dt == DT_RAW10 || dt == DT_RAW12 || dt == DT_RAW14;
  endfunction
endpackage

// File: rtl/mipi_csi_beat_counter.sv
// mipi_csi_beat_counter: loads ceil(wc/8) payload beats and counts them down
module mipi_csi_beat_counter (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        load_i,
  input  logic [15:0] wc_i,
  input  logic        dec_i,
  output logic [13:0] count_o,
  output logic        zero_o,
  output logic        last_o
);
  always_ff @(posedge clk_i)
    if (reset_i) count_o <= '0;
    else if (load_i) count_o <= 14'((17'(wc_i) + 17'd7) >> 3);
    else if (dec_i && !zero_o) count_o <= count_o - 14'd1;
  assign zero_o = count_o == '0;
  assign last_o = count_o == 14'd1;
endmodule

// File: rtl/mipi_csi_rx_line_sequencer.sv
// mipi_csi_rx_line_sequencer: frame/line FSM gating packet payload into the RAW depacker
module mipi_csi_rx_line_sequencer
  import mipi_csi_pkg::*;
#(
  parameter int GUARD_CYCLES = 4,
  parameter int LINE_CNT_W   = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  enable_i,
  input  logic [1:0]            vc_select_i,
  input  logic                  header_valid_i,
  input  logic [7:0]            header_id_i,
  input  logic [15:0]           header_wc_i,
  input  logic                  payload_valid_i,
  input  logic [63:0]           payload_i,
  output logic                  depack_valid_o,
  output logic [63:0]           depack_data_o,
  output logic [2:0]            depack_type_o,
  output logic                  frame_active_o,
  output logic                  frame_start_o,
  output logic                  frame_end_o,
  output logic                  line_start_o,
  output logic [LINE_CNT_W-1:0] line_count_o,
  output logic [LINE_CNT_W-1:0] last_frame_lines_o,
  output logic                  err_unsupported_o,
  output logic                  err_overrun_o,
  output logic                  err_truncated_o
);
  localparam int GW = $clog2(GUARD_CYCLES + 1);
  state_t          state;
  logic [GW-1:0]   gcnt;
  logic            pv_q;
  logic [13:0]     beats_left;
  logic            beats_zero, beats_last;
  logic            hdr, fwd, pv_fall, load;
  logic [5:0]      dt;
  assign dt      = header_id_i[5:0];
  assign hdr     = header_valid_i && header_id_i[7:6] == vc_select_i;
  assign fwd     = state == ST_LINE && payload_valid_i && !beats_zero;
  assign pv_fall = pv_q && !payload_valid_i;
  assign load    = state == ST_FRAME && hdr && is_raw(dt);
  mipi_csi_beat_counter u_beats (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (load),
    .wc_i    (header_wc_i),
    .dec_i   (fwd),
    .count_o (beats_left),
    .zero_o  (beats_zero),
    .last_o  (beats_last)
  );
  always_ff @(posedge clk_i)
    if (reset_i) begin
      state              <= ST_IDLE;
      gcnt               <= '0;
      pv_q               <= 1'b0;
      depack_valid_o     <= 1'b0;
      depack_data_o      <= '0;
      depack_type_o      <= '0;
      frame_active_o     <= 1'b0;
      frame_start_o      <= 1'b0;
      frame_end_o        <= 1'b0;
      line_start_o       <= 1'b0;
      line_count_o       <= '0;
      last_frame_lines_o <= '0;
      err_unsupported_o  <= 1'b0;
      err_overrun_o      <= 1'b0;
      err_truncated_o    <= 1'b0;
    end else begin
      pv_q              <= payload_valid_i;
      depack_valid_o    <= fwd;
      depack_data_o     <= fwd ? payload_i : '0;
      frame_start_o     <= 1'b0;
      frame_end_o       <= 1'b0;
      line_start_o      <= 1'b0;
      err_truncated_o   <= 1'b0;
      err_overrun_o     <= hdr && (state == ST_LINE || state == ST_GUARD);
      err_unsupported_o <= state == ST_FRAME && hdr && dt >= DT_LONG_MIN && !is_raw(dt);
      unique case (state)
        ST_IDLE:
          if (hdr && dt == DT_FS && enable_i) begin
            state          <= ST_FRAME;
            frame_start_o  <= 1'b1;
            frame_active_o <= 1'b1;
            line_count_o   <= '0;
          end
        ST_FRAME:
          if (hdr && dt == DT_FE) begin
            state              <= ST_IDLE;
            frame_end_o        <= 1'b1;
            frame_active_o     <= 1'b0;
            last_frame_lines_o <= line_count_o;
          end else if (load) begin
            state         <= header_wc_i == '0 ? ST_GUARD : ST_LINE;
            gcnt          <= GW'(GUARD_CYCLES - 1);
            depack_type_o <= dt[2:0] & DT_TYPE_MASK;
            line_start_o  <= 1'b1;
            line_count_o  <= &line_count_o ? line_count_o : line_count_o + 1'b1;
          end else if (hdr && dt >= DT_LONG_MIN && header_wc_i != '0) begin
            state <= ST_DROP;
          end
        ST_LINE:
          if (fwd && beats_last) begin
            state <= ST_GUARD;
            gcnt  <= GW'(GUARD_CYCLES - 1);
          end else if (pv_fall) begin
            state           <= ST_GUARD;
            gcnt            <= GW'(GUARD_CYCLES - 1);
            err_truncated_o <= 1'b1;
          end
        ST_GUARD:
          if (gcnt == '0) state <= ST_FRAME;
          else gcnt <= gcnt - 1'b1;
        ST_DROP:
          if (pv_fall) state <= ST_FRAME;
        default: state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_mipi_csi_rx_line_sequencer.sv
// tb_mipi_csi_rx_line_sequencer: scoreboarded scenarios for the CSI-2 line sequencer
module tb_mipi_csi_rx_line_sequencer;
  import mipi_csi_pkg::*;
  localparam int G = 4;
  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        enable_i = 1'b1;
  logic [1:0]  vc_select_i = 2'd0;
  logic        header_valid_i = 1'b0;
  logic [7:0]  header_id_i = '0;
  logic [15:0] header_wc_i = '0;
  logic        payload_valid_i = 1'b0;
  logic [63:0] payload_i = '0;
  logic        depack_valid_o;
  logic [63:0] depack_data_o;
  logic [2:0]  depack_type_o;
  logic        frame_active_o, frame_start_o, frame_end_o, line_start_o;
  logic [15:0] line_count_o, last_frame_lines_o;
  logic        err_unsupported_o, err_overrun_o, err_truncated_o;

  mipi_csi_rx_line_sequencer #(.GUARD_CYCLES(G), .LINE_CNT_W(16)) dut (
    .clk_i(clk), .reset_i(reset_i), .enable_i(enable_i), .vc_select_i(vc_select_i),
    .header_valid_i(header_valid_i), .header_id_i(header_id_i), .header_wc_i(header_wc_i),
    .payload_valid_i(payload_valid_i), .payload_i(payload_i),
    .depack_valid_o(depack_valid_o), .depack_data_o(depack_data_o), .depack_type_o(depack_type_o),
    .frame_active_o(frame_active_o), .frame_start_o(frame_start_o), .frame_end_o(frame_end_o),
    .line_start_o(line_start_o), .line_count_o(line_count_o), .last_frame_lines_o(last_frame_lines_o),
    .err_unsupported_o(err_unsupported_o), .err_overrun_o(err_overrun_o), .err_truncated_o(err_truncated_o)
  );

  always #5 clk = ~clk;

  typedef struct {logic [63:0] d; int c;} exp_t;
  exp_t q[$];
  int cyc, nvec, nerr;
  int n_fs, n_fe, n_ls, n_unsup, n_ovr, n_trunc, n_fwd;
  exp_t e;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (frame_start_o) n_fs++;
    if (frame_end_o) n_fe++;
    if (line_start_o) n_ls++;
    if (err_unsupported_o) n_unsup++;
    if (err_overrun_o) n_ovr++;
    if (err_truncated_o) n_trunc++;
    if (depack_valid_o) begin
      n_fwd++;
      nvec++;
      if (q.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_beat: got data %h at cycle %0d, required no beat", depack_data_o, cyc);
      end else begin
        e = q.pop_front();
        if (depack_data_o !== e.d || cyc !== e.c) begin
          nerr++;
          $display("FAIL beat_data: got %h at cycle %0d, required %h at cycle %0d", depack_data_o, cyc, e.d, e.c);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic hdr(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc);
    header_valid_i = 1'b1;
    header_id_i = {vc, dt};
    header_wc_i = wc;
    tick();
    header_valid_i = 1'b0;
  endtask

  task automatic beats(input int n, input int nfwd);
    for (int i = 0; i < n; i++) begin
      payload_valid_i = 1'b1;
      payload_i = {$urandom, $urandom};
      if (i < nfwd) q.push_back('{payload_i, cyc + 1});
      tick();
    end
    payload_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    idle(3);
    reset_i = 1'b0;
    tick();
    nvec++;
    if ({depack_valid_o, frame_active_o, line_count_o, depack_type_o, last_frame_lines_o} !== '0) begin
      nerr++;
      $display("FAIL reset_state: got valid=%b active=%b lines=%0d type=%0d last=%0d, required all 0",
               depack_valid_o, frame_active_o, line_count_o, depack_type_o, last_frame_lines_o);
    end
  endtask

  task automatic test_basic_frame();
    int fs0 = n_fs, fe0 = n_fe, fw0 = n_fwd;
    hdr(2'd0, DT_FS, 16'd0);
    hdr(2'd0, DT_LS, 16'd0);
    hdr(2'd0, DT_RAW10, 16'd40);
    beats(5, 5);
    idle(G + 3);
    nvec++;
    if (depack_type_o !== 3'd3 || line_count_o !== 16'd1 || frame_active_o !== 1'b1) begin
      nerr++;
      $display("FAIL basic_line: got type=%0d lines=%0d active=%b, required 3 1 1", depack_type_o, line_count_o, frame_active_o);
    end
    hdr(2'd0, DT_LE, 16'd0);
    hdr(2'd0, DT_FE, 16'd0);
    idle(2);
    nvec++;
    if (n_fs - fs0 !== 1 || n_fe - fe0 !== 1 || n_fwd - fw0 !== 5) begin
      nerr++;
      $display("FAIL basic_pulses: got fs=%0d fe=%0d beats=%0d, required 1 1 5", n_fs - fs0, n_fe - fe0, n_fwd - fw0);
    end
    nvec++;
    if (last_frame_lines_o !== 16'd1 || frame_active_o !== 1'b0) begin
      nerr++;
      $display("FAIL basic_fe: got last=%0d active=%b, required 1 0", last_frame_lines_o, frame_active_o);
    end
  endtask

  task automatic test_ceil_wc();
    int fw0, er0;
    hdr(2'd0, DT_FS, 16'd0);
    fw0 = n_fwd;
    er0 = n_trunc + n_ovr + n_unsup;
    hdr(2'd0, DT_RAW12, 16'd20);
    beats(4, 3);
    idle(G + 3);
    nvec++;
    if (n_fwd - fw0 !== 3 || depack_type_o !== 3'd4 || n_trunc + n_ovr + n_unsup - er0 !== 0) begin
      nerr++;
      $display("FAIL ceil_wc: got beats=%0d type=%0d errs=%0d, required 3 4 0", n_fwd - fw0, depack_type_o, n_trunc + n_ovr + n_unsup - er0);
    end
    nvec++;
    if (line_count_o !== 16'd1) begin
      nerr++;
      $display("FAIL ceil_lines: got %0d, required 1", line_count_o);
    end
  endtask

  task automatic test_truncated();
    int fw0 = n_fwd, tr0 = n_trunc, ls0 = n_ls;
    hdr(2'd0, DT_RAW14, 16'd64);
    beats(5, 5);
    idle(2);
    nvec++;
    if (n_trunc - tr0 !== 1 || depack_type_o !== 3'd5) begin
      nerr++;
      $display("FAIL truncated: got pulses=%0d type=%0d, required 1 5", n_trunc - tr0, depack_type_o);
    end
    idle(G);
    hdr(2'd0, DT_RAW10, 16'd8);
    beats(1, 1);
    idle(G + 3);
    nvec++;
    if (n_ls - ls0 !== 2 || line_count_o !== 16'd3 || n_fwd - fw0 !== 6 || n_trunc - tr0 !== 1) begin
      nerr++;
      $display("FAIL after_guard: got ls=%0d lines=%0d beats=%0d trunc=%0d, required 2 3 6 1",
               n_ls - ls0, line_count_o, n_fwd - fw0, n_trunc - tr0);
    end
  endtask

  task automatic test_overrun();
    int ov0 = n_ovr, ls0 = n_ls;
    logic [15:0] lc0 = line_count_o;
    hdr(2'd0, DT_RAW10, 16'd16);
    beats(2, 2);
    idle(1);
    hdr(2'd0, DT_RAW10, 16'd16);
    beats(2, 0);
    idle(G + 3);
    nvec++;
    if (n_ovr - ov0 !== 1) begin
      nerr++;
      $display("FAIL overrun_pulse: got %0d, required 1", n_ovr - ov0);
    end
    nvec++;
    if (line_count_o !== lc0 + 16'd1 || n_ls - ls0 !== 1) begin
      nerr++;
      $display("FAIL overrun_lines: got lines=%0d ls=%0d, required %0d 1", line_count_o, n_ls - ls0, lc0 + 16'd1);
    end
  endtask

  task automatic test_unsupported();
    int un0 = n_unsup, fw0 = n_fwd;
    logic [15:0] lc0 = line_count_o;
    hdr(2'd0, 6'h2A, 16'd16);
    beats(2, 0);
    idle(3);
    hdr(2'd1, DT_RAW10, 16'd16);
    beats(2, 0);
    idle(3);
    nvec++;
    if (n_unsup - un0 !== 1 || n_fwd - fw0 !== 0 || line_count_o !== lc0) begin
      nerr++;
      $display("FAIL unsupported: got unsup=%0d beats=%0d lines=%0d, required 1 0 %0d", n_unsup - un0, n_fwd - fw0, line_count_o, lc0);
    end
    hdr(2'd0, DT_RAW10, 16'd8);
    beats(1, 1);
    idle(G + 3);
    nvec++;
    if (line_count_o !== lc0 + 16'd1 || n_fwd - fw0 !== 1) begin
      nerr++;
      $display("FAIL after_drop: got lines=%0d beats=%0d, required %0d 1", line_count_o, n_fwd - fw0, lc0 + 16'd1);
    end
  endtask

  task automatic test_reset_midline();
    int fs0, ls0;
    hdr(2'd0, DT_RAW10, 16'd40);
    beats(2, 2);
    payload_valid_i = 1'b1;
    payload_i = {$urandom, $urandom};
    reset_i = 1'b1;
    tick();
    nvec++;
    if ({depack_valid_o, depack_data_o, depack_type_o, frame_active_o, frame_start_o, frame_end_o, line_start_o,
         line_count_o, last_frame_lines_o, err_unsupported_o, err_overrun_o, err_truncated_o} !== '0) begin
      nerr++;
      $display("FAIL reset_midline: got valid=%b type=%0d active=%b lines=%0d last=%0d, required all 0",
               depack_valid_o, depack_type_o, frame_active_o, line_count_o, last_frame_lines_o);
    end
    reset_i = 1'b0;
    payload_valid_i = 1'b0;
    idle(1);
    fs0 = n_fs;
    ls0 = n_ls;
    enable_i = 1'b0;
    hdr(2'd0, DT_FS, 16'd0);
    hdr(2'd0, DT_RAW10, 16'd8);
    beats(1, 0);
    idle(3);
    nvec++;
    if (frame_active_o !== 1'b0 || n_fs - fs0 !== 0 || n_ls - ls0 !== 0 || line_count_o !== 16'd0) begin
      nerr++;
      $display("FAIL disabled_fs: got active=%b fs=%0d ls=%0d lines=%0d, required 0 0 0 0",
               frame_active_o, n_fs - fs0, n_ls - ls0, line_count_o);
    end
    enable_i = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_ceil_wc();
    test_truncated();
    test_overrun();
    test_unsupported();
    test_reset_midline();
    idle(2);
    nvec++;
    if (q.size() !== 0) begin
      nerr++;
      $display("FAIL missing_beats: got %0d beats still expected, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
